fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded at reset.
REQ-002 SHALL have parameter DEPTH, default 2, fetch buffer entries (legal range 2..8).
REQ-003 SHALL have parameter MEM_WORDS, default 1280, instruction memory size in 32-bit words.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: ports clk and rst_n.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1, async active-low reset.
REQ-007 SHALL have port start, input, 1, begin fetching from current PC.
REQ-008 SHALL have port imem_addr, output, 32, byte address to instruction memory (combinational read).
REQ-009 SHALL have port imem_instr, input, 32, instruction word returned same cycle.
REQ-010 SHALL have port redirect_valid, input, 1, branch/jump redirect request.
REQ-011 SHALL have port redirect_pc, input, 32, redirect target byte address.
REQ-012 SHALL have port out_valid, output, 1, out_instr/out_pc valid to decode.
REQ-013 SHALL have port out_ready, input, 1, decode accepts.
REQ-014 SHALL have port out_instr, output, 32, fetched instruction.
REQ-015 SHALL have port out_pc, output, 32, byte address of out_instr.
REQ-016 SHALL have ports busy, halted and fault: each output, 1, status.

Function
REQ-017 SHALL implement states IDLE, FETCH, HALT, FAULT; imem_addr = PC register in every state.
REQ-018 IDLE: start=1 -> FETCH next edge; other inputs except redirect are ignored.
REQ-019 FETCH: push {PC, imem_instr} and PC <= PC+4 each cycle the buffer has space (count<DEPTH, or count==DEPTH with a pop the same cycle).
REQ-020 Latency: start in cycle N -> first push in N+1 -> out_valid=1 in N+2; sustained throughput of one instruction per cycle while out_ready=1.
REQ-021 Pop occurs when out_valid && out_ready; out_* are registered buffer-head outputs held stable while out_valid && !out_ready.
REQ-022 Redirect has priority over push and pop: buffer flushed (count<=0, out_valid<=0), PC<=redirect_pc, no push that cycle; any handshake that same cycle is discarded.
REQ-023 Redirect in HALT or FAULT -> FETCH, flags cleared; redirect in IDLE loads PC and stays IDLE.
REQ-024 Before a push: if PC[1:0]!=0 or PC >= MEM_WORDS*4 -> FAULT, no push, PC held; already-buffered entries still drain.
REQ-025 PC arithmetic SHALL be 32-bit modulo 2^32; any wrap is caught by REQ-024.
REQ-026 halted=1 iff state HALT; fault=1 iff state FAULT; busy = (state==FETCH) || (count!=0).
REQ-027 start while in FETCH, HALT or FAULT SHALL be ignored.

Reset
REQ-028 rst_n=0 SHALL immediately set: state IDLE, PC=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0, halted=0, fault=0, busy=0.
REQ-029 Reset asserted mid-fetch SHALL discard all buffered entries; no output handshake completes in a reset cycle.

Configuration
REQ-030 Macro FETCH_ZERO_HALT_EN defined: fetched word 32'h0000_0000 is not pushed; state -> HALT, PC held at the zero word's address.
REQ-031 Macro FETCH_ZERO_HALT_EN undefined: zero words are pushed like any other instruction; HALT is unreachable and halted stays 0.

Structure
REQ-032 Shared package fetch_pkg SHALL hold: state enum, INSTR_W=32, ADDR_W=32, PC_STEP=4, fetch-entry struct {pc, instr}.
REQ-033 Buffer SHALL be sub-module fetch_fifo (DEPTH entries of the fetch-entry struct, push/pop/flush, count); the sequencer holds only FSM and PC.

Verification
REQ-034 12-instruction program at words 0..11, zeros after, out_ready=1, macro on: start -> 12 pops with out_pc 0x00..0x2C in order, then halted=1, busy=0, PC=0x30.
REQ-035 out_ready=0 for 5 cycles after start: buffer fills to DEPTH, PC stops at RESET_PC+4*DEPTH, out_pc=0x00 held stable; releasing it resumes in order with no gap.
REQ-036 Redirect to 0x20 while 2 entries buffered: next cycle out_valid=0; the cycle after, out_pc=0x20 and out_instr=word 8.
REQ-037 Redirect to 0x13FC, then 0x1400: word 1279 delivered, then fault=1 with no push; redirect to 0x0 -> FETCH, fault=0.
REQ-038 Redirect to 0x02 -> fault=1 immediately; rst_n pulse mid-FETCH -> all outputs at reset values within the same cycle, PC=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its buffer.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry shift FIFO of {pc, instr}; the head entry is a
// register, so the head fields feed the decode outputs directly.
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   push, push_data- write one entry (caller guarantees space)
//   pop            - drop the head entry (ignored when empty)
//   flush          - discard all entries; wins over push/pop
//   head, valid    - head entry and its valid flag (registered)
//   count          - current occupancy
//   count_next_c   - occupancy after this edge (combinational)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next_c
);

  fetch_entry_t     entries   [DEPTH];
  fetch_entry_t     entries_n [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] wr_idx;
  logic             do_pop;
  logic             valid_q;

  // Next occupancy and contents: shift on pop, write behind the survivors.
  always_comb begin
    entries_n = entries;
    cnt_n     = cnt_q;
    wr_idx    = cnt_q;
    do_pop    = pop && (cnt_q != '0);
    if (flush) begin
      cnt_n = '0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          entries_n[i] = entries[i+1];
        end
        wr_idx = cnt_q - CNT_W'(1);
      end
      if (push) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (CNT_W'(i) == wr_idx) begin
            entries_n[i] = push_data;
          end
        end
      end
      cnt_n = cnt_q + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_n;
      valid_q <= (cnt_n != '0);
      entries <= entries_n;
    end
  end

  assign head         = entries[0];
  assign valid        = valid_q;
  assign count        = cnt_q;
  assign count_next_c = cnt_n;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through a combinational-read
// instruction memory and queues {pc, instr} into a fetch buffer for decode.
// Optional build macro FETCH_ZERO_HALT_EN: an all-zero fetched word halts
// fetching (not queued, PC parked on it); otherwise zero words are ordinary.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   start                      - leave IDLE and begin fetching
//   imem_addr / imem_instr     - instruction memory byte address / word
//   redirect_valid/redirect_pc - flush buffer and restart at a new PC
//   out_valid/out_ready        - decode handshake
//   out_instr/out_pc           - buffer head entry
//   busy, halted, fault        - status
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MEM_WORDS = 1280
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               busy,
  output logic               halted,
  output logic               fault
);

  localparam int unsigned     CNT_W     = $clog2(DEPTH + 1);
  localparam int unsigned     EXT_W     = ADDR_W + 1;
  localparam logic [EXT_W-1:0] MEM_BYTES = EXT_W'(MEM_WORDS) * EXT_W'(PC_STEP);

  fetch_state_e      state_q;
  fetch_state_e      state_n;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_n;
  logic              push;
  logic              pop;
  logic              flush;
  logic              space;
  logic              pc_bad;
  logic              halted_q;
  logic              fault_q;
  logic              busy_q;
  fetch_entry_t      push_data;
  fetch_entry_t      head;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next_c;

  // Next state, next PC and buffer controls; redirect overrides everything.
  always_comb begin
    state_n   = state_q;
    pc_n      = pc_q;
    push      = 1'b0;
    flush     = 1'b0;
    pop       = out_valid && out_ready && !redirect_valid;
    space     = (count < CNT_W'(DEPTH)) || pop;
    pc_bad    = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= MEM_BYTES);
    push_data = '{pc: pc_q, instr: imem_instr};
    if (redirect_valid) begin
      flush = 1'b1;
      pc_n  = redirect_pc;
      if (state_q == HALT || state_q == FAULT) begin
        state_n = FETCH;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_n = FETCH;
          end
        end
        FETCH: begin
          if (space) begin
            if (pc_bad) begin
              state_n = FAULT;
`ifdef FETCH_ZERO_HALT_EN
            end else if (imem_instr == '0) begin
              state_n = HALT;
`endif
            end else begin
              push = 1'b1;
              pc_n = pc_q + ADDR_W'(PC_STEP);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State, PC and status registers; status flags track the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      pc_q     <= pc_n;
      halted_q <= (state_n == HALT);
      fault_q  <= (state_n == FAULT);
      busy_q   <= (state_n == FETCH) || (count_next_c != '0);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .push_data    (push_data),
    .pop          (pop),
    .flush        (flush),
    .head         (head),
    .valid        (out_valid),
    .count        (count),
    .count_next_c (count_next_c)
  );

  assign imem_addr = pc_q;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a queue-based reference model is
// compared every cycle, plus directed scenarios with literal expectations.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          DEPTH     = 2;
  localparam int          MEM_WORDS = 1280;

`ifdef FETCH_ZERO_HALT_EN
  localparam bit ZERO_HALT = 1'b1;
`else
  localparam bit ZERO_HALT = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_HALT  = 2;
  localparam int M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        busy;
  logic        halted;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [MEM_WORDS];

  // Reference model state
  int          m_st = M_IDLE;
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] q_pc [$];
  logic [31:0] q_in [$];

  // Completed handshakes seen at the DUT outputs
  logic [31:0] log_pc [$];
  logic [31:0] log_in [$];

  fetch_sequencer #(
    .RESET_PC  (RESET_PC),
    .DEPTH     (DEPTH),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .busy           (busy),
    .halted         (halted),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] prog(int i);
    return 32'hA000_0000 | 32'(i + 1);
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    if (longint'(a) < longint'(MEM_WORDS) * 4) return mem[w];
    return 32'hDEAD_BEEF;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    rst_n          = 1'b1;
    #1;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // Reference model: buffer as a queue, advanced once per rising edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_st = M_IDLE;
        m_pc = RESET_PC;
        q_pc.delete();
        q_in.delete();
      end else if (redirect_valid) begin
        q_pc.delete();
        q_in.delete();
        m_pc = redirect_pc;
        if (m_st == M_HALT || m_st == M_FAULT) m_st = M_FETCH;
      end else begin
        if (q_pc.size() != 0 && out_ready) begin
          void'(q_pc.pop_front());
          void'(q_in.pop_front());
        end
        if (m_st == M_IDLE) begin
          if (start) m_st = M_FETCH;
        end else if (m_st == M_FETCH && q_pc.size() < DEPTH) begin
          if (m_pc % 4 != 0 || longint'(m_pc) >= longint'(MEM_WORDS) * 4) begin
            m_st = M_FAULT;
          end else if (ZERO_HALT && mem_word(m_pc) == 32'h0) begin
            m_st = M_HALT;
          end else begin
            q_pc.push_back(m_pc);
            q_in.push_back(mem_word(m_pc));
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, plus handshake logging.
  initial begin
    forever begin
      @(negedge clk);
      check("out_valid", 32'(out_valid), 32'(q_pc.size() != 0));
      if (q_pc.size() != 0) begin
        check("out_pc", out_pc, q_pc[0]);
        check("out_instr", out_instr, q_in[0]);
      end
      check("imem_addr", imem_addr, m_pc);
      check("busy", 32'(busy), 32'(m_st == M_FETCH || q_pc.size() != 0));
      check("halted", 32'(halted), 32'(m_st == M_HALT));
      check("fault", 32'(fault), 32'(m_st == M_FAULT));
      if (rst_n && out_valid && out_ready && !redirect_valid) begin
        log_pc.push_back(out_pc);
        log_in.push_back(out_instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
    for (int i = 0; i < 12; i++) mem[i] = prog(i);
    mem[1279] = 32'hCAFE_F00D;

    // Reset values and the 12-word program with decode always ready
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    log_pc.delete();
    log_in.delete();
    out_ready = 1'b1;
    start     = 1'b1;
    cyc();
    start = 1'b0;
    check("lat_n1_valid", 32'(out_valid), 32'h0);
    check("lat_n1_busy", 32'(busy), 32'h1);
    cyc();
    check("lat_n2_valid", 32'(out_valid), 32'h1);
    check("lat_n2_pc", out_pc, 32'h0);
    check("lat_n2_instr", out_instr, 32'hA000_0001);
    repeat (25) cyc();
    if (log_pc.size() < 12) begin
      check("prog_pop_count_min", 32'(log_pc.size()), 32'd12);
    end else begin
      for (int i = 0; i < 12; i++) begin
        check("prog_pop_pc", log_pc[i], 32'(i * 4));
        check("prog_pop_instr", log_in[i], prog(i));
      end
    end
`ifdef FETCH_ZERO_HALT_EN
    check("prog_pop_count", 32'(log_pc.size()), 32'd12);
    check("prog_halted", 32'(halted), 32'h1);
    check("prog_busy", 32'(busy), 32'h0);
    check("prog_pc", imem_addr, 32'h30);
`else
    check("prog_halted", 32'(halted), 32'h0);
    check("prog_busy", 32'(busy), 32'h1);
    if (log_pc.size() < 13) begin
      check("prog_pop_count_min", 32'(log_pc.size()), 32'd13);
    end else begin
      check("prog_zero_pc", log_pc[12], 32'h30);
      check("prog_zero_instr", log_in[12], 32'h0);
    end
`endif

    // Back-pressure: buffer fills, head held, then drains with no bubble
    do_reset();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (k >= 1) check("bp_head_pc_stable", out_pc, 32'h0);
    end
    check("bp_pc_stop", imem_addr, RESET_PC + 32'(4 * DEPTH));
    check("bp_valid", 32'(out_valid), 32'h1);
    check("bp_instr", out_instr, 32'hA000_0001);
    log_pc.delete();
    log_in.delete();
    out_ready = 1'b1;
    repeat (6) cyc();
    check("bp_resume_count", 32'(log_pc.size()), 32'd6);
    if (log_pc.size() == 6) begin
      for (int i = 0; i < 6; i++) check("bp_resume_pc", log_pc[i], 32'(i * 4));
    end

    // Redirect with two entries buffered and a same-cycle handshake
    do_reset();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    check("rd_full_valid", 32'(out_valid), 32'h1);
    log_pc.delete();
    log_in.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    out_ready      = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    check("rd_flush_valid", 32'(out_valid), 32'h0);
    check("rd_pc", imem_addr, 32'h20);
    cyc();
    check("rd_new_valid", 32'(out_valid), 32'h1);
    check("rd_new_pc", out_pc, 32'h20);
    check("rd_new_instr", out_instr, prog(8));
    check("rd_dropped_handshake", 32'(log_pc.size()), 32'd0);

    // Last legal word, then the end of memory faults; redirect recovers
    do_reset();
    out_ready = 1'b1;
    start     = 1'b1;
    cyc();
    start          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h13FC;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    check("end_last_pc", out_pc, 32'h13FC);
    check("end_last_instr", out_instr, 32'hCAFE_F00D);
    check("end_no_fault_yet", 32'(fault), 32'h0);
    cyc();
    check("end_fault", 32'(fault), 32'h1);
    check("end_pc_held", imem_addr, 32'h1400);
    check("end_no_push", 32'(out_valid), 32'h0);
    check("end_busy", 32'(busy), 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    cyc();
    redirect_valid = 1'b0;
    check("end_recover_fault", 32'(fault), 32'h0);
    check("end_recover_busy", 32'(busy), 32'h1);
    cyc();
    check("end_recover_pc", out_pc, 32'h0);

    // Redirect in IDLE only loads the PC
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    cyc();
    redirect_valid = 1'b0;
    check("idle_rd_pc", imem_addr, 32'h10);
    check("idle_rd_busy", 32'(busy), 32'h0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    check("idle_rd_first_pc", out_pc, 32'h10);
    check("idle_rd_first_instr", out_instr, prog(4));

    // Misaligned redirect faults; start ignored; reset mid-fetch
    do_reset();
    out_ready = 1'b1;
    start     = 1'b1;
    cyc();
    start          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2;
    cyc();
    redirect_valid = 1'b0;
    check("mis_pc", imem_addr, 32'h2);
    cyc();
    check("mis_fault", 32'(fault), 32'h1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("mis_start_ignored", 32'(fault), 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    cyc();
    check("mid_busy", 32'(busy), 32'h1);
    check("mid_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_pc", out_pc, 32'h0);
    check("arst_instr", out_instr, 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_halted", 32'(halted), 32'h0);
    check("arst_fault", 32'(fault), 32'h0);
    check("arst_imem_addr", imem_addr, RESET_PC);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post_rst_idle", 32'(busy), 32'h0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
